// File: rtl/pivot_row_reader.sv
`default_nettype none
// ============================================================================
//  Module   : pivot_row_reader
//  Purpose  : Streams the normalised pivot row out of the pivot-row BRAM as an
//             AXI-Stream master. Reads are issued on a native BRAM read port;
//             returning data lands in a small FIFO so consumer backpressure
//             never drops a word.
//  Ports    : clk, reset (sync, active-high)
//             start / num_cols      - row request (num_cols latched on accept)
//             cont / terminate      - sticky row-done / zero-length-row flags
//             ren / ridx / rdata    - BRAM read port (rdata RD_LAT after ren)
//             M_AXIS_PIVOTROW_*     - AXI-Stream master toward row elimination
//  Revision : 1.0 - initial release
// ============================================================================
module pivot_row_reader #(
  parameter int DATAW      = 32,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      num_cols,
  output logic             cont,
  output logic             terminate,
  output logic             ren,
  output logic [15:0]      ridx,
  input  logic [DATAW-1:0] rdata,
  output logic [DATAW-1:0] M_AXIS_PIVOTROW_TDATA,
  output logic             M_AXIS_PIVOTROW_TVALID,
  input  logic             M_AXIS_PIVOTROW_TREADY,
  output logic             M_AXIS_PIVOTROW_TLAST
);

  localparam int c_ptr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w  = $clog2(FIFO_DEPTH + 1);
  localparam int c_infl_w = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             r_state;
  logic [15:0]        r_num_cols;
  logic [15:0]        r_issued;
  logic [15:0]        r_sent;
  logic               r_cont;
  logic               r_terminate;
  logic [RD_LAT-1:0]  r_vld;
  logic [DATAW-1:0]   r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic [c_infl_w-1:0] w_inflight;
  logic                w_ren;
  logic                w_push;
  logic                w_valid;
  logic                w_pop;
  logic                w_last;

  // Reads still travelling through the BRAM pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + c_infl_w'(r_vld[i]);
    end
  end

  // Credit check: a read is only issued when the FIFO is guaranteed to have
  // room for it on return, counting everything already in flight.
  assign w_ren   = (r_state == S_STREAM) && (r_issued < r_num_cols) &&
                   ((int'(r_count) + int'(w_inflight)) < FIFO_DEPTH);
  assign w_push  = r_vld[RD_LAT-1];
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && M_AXIS_PIVOTROW_TREADY;
  assign w_last  = w_valid && (r_sent == r_num_cols - 16'd1);

  assign ren                    = w_ren;
  assign ridx                   = r_issued;
  assign cont                   = r_cont;
  assign terminate              = r_terminate;
  assign M_AXIS_PIVOTROW_TDATA  = r_mem[r_rd_ptr];
  assign M_AXIS_PIVOTROW_TVALID = w_valid;
  assign M_AXIS_PIVOTROW_TLAST  = w_last;

  // Read-tag shift register; clearing it on reset discards in-flight reads.
  generate
    if (RD_LAT == 1) begin : g_vld_single
      always_ff @(posedge clk) begin
        if (reset) r_vld <= '0;
        else       r_vld <= w_ren;
      end
    end else begin : g_vld_shift
      always_ff @(posedge clk) begin
        if (reset) r_vld <= '0;
        else       r_vld <= {r_vld[RD_LAT-2:0], w_ren};
      end
    end
  endgenerate

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    if (int'(p) == FIFO_DEPTH - 1) return '0;
    return p + c_ptr_w'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_num_cols  <= '0;
      r_issued    <= '0;
      r_sent      <= '0;
      r_cont      <= 1'b0;
      r_terminate <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_num_cols  <= num_cols;
            r_issued    <= '0;
            r_sent      <= '0;
            r_cont      <= 1'b0;
            r_terminate <= 1'b0;
            if (num_cols == 16'd0) begin
              r_terminate <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state     <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (w_ren) r_issued <= r_issued + 16'd1;
          if (w_pop) begin
            r_sent <= r_sent + 16'd1;
            if (w_last) begin
              r_cont  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
